// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS generator/checker pair: default Galois tap
// mask and the checker's synchronisation states.
package lfsr_pkg;

    localparam logic [15:0] DEFAULT_TAPS = 16'b0000000000011101;

    typedef enum logic {
        ACQUIRE = 1'b0,
        CHECK   = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising Galois-LFSR PRBS checker: seeds its local register from
// the received stream, then free-runs it and compares each incoming bit.
module prbs_checker
    import lfsr_pkg::*;
#(
    parameter logic [15:0] TAPS      = DEFAULT_TAPS,
    parameter bit          INVERT    = 1'b0,
    parameter int          LOSS_ERRS = 4,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             din,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    localparam int             N         = $bits(TAPS);
    localparam int             ACQ_W     = $clog2(N + 1);
    localparam logic [ACQ_W-1:0] ACQ_LAST  = ACQ_W'(N - 1);
    localparam logic [3:0]     LOSS_LAST = 4'(LOSS_ERRS - 1);

    state_t           state;
    logic [N-1:0]     loc;
    logic [N-1:0]     loc_next;
    logic [ACQ_W-1:0] acq_cnt;
    logic [3:0]       miss_cnt;
    logic             fb_bit;
    logic             mismatch;
    logic             lose_lock;

    // While acquiring, the received bit is the generator's own feedback, so
    // after N shifts the stale seed has been pushed out entirely.
    always_comb begin
        fb_bit    = ((state == ACQUIRE) ? din : loc[N-1]) ^ INVERT;
        loc_next  = {loc[N-2:0], 1'b0} ^ (fb_bit ? TAPS : '0);
        mismatch  = enable && (state == CHECK) && (din != loc[N-1]);
        lose_lock = mismatch && (miss_cnt == LOSS_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            loc      <= '1;
            state    <= ACQUIRE;
            acq_cnt  <= '0;
            miss_cnt <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= mismatch;
            if (enable) begin
                loc <= loc_next;
                case (state)
                    ACQUIRE: begin
                        if (acq_cnt == ACQ_LAST) begin
                            state   <= CHECK;
                            acq_cnt <= '0;
                            locked  <= 1'b1;
                        end else begin
                            acq_cnt <= acq_cnt + ACQ_W'(1);
                        end
                    end
                    CHECK: begin
                        if (lose_lock) begin
                            state    <= ACQUIRE;
                            acq_cnt  <= '0;
                            miss_cnt <= '0;
                            locked   <= 1'b0;
                        end else if (mismatch) begin
                            miss_cnt <= miss_cnt + 4'd1;
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        state  <= ACQUIRE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (mismatch),
        .clr  (clear),
        .count(err_count)
    );

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench: a bench-side Galois generator feeds two checkers; the second
// has a narrow, slow-to-unlock counter so saturation is reachable quickly.
module tb_prbs_checker;
    import lfsr_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        din = 1'b0;
    logic        din_sat = 1'b0;
    logic        clear = 1'b0;
    logic        locked, err;
    logic [15:0] err_count;
    logic        locked_sat, err_sat;
    logic [3:0]  err_count_sat;

    int          n_checks = 0;
    int          n_errors = 0;
    int          err_seen = 0;
    int          err_sat_seen = 0;
    int          unlock_seen = 0;
    logic [15:0] gen = 16'hACE1;
    logic        lost;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .din      (din),
        .clear    (clear),
        .locked   (locked),
        .err      (err),
        .err_count(err_count)
    );

    prbs_checker #(
        .LOSS_ERRS(15),
        .CNT_W    (4)
    ) dut_sat (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .din      (din_sat),
        .clear    (clear),
        .locked   (locked_sat),
        .err      (err_sat),
        .err_count(err_count_sat)
    );

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task applyStimulus(input logic rst, input logic en, input logic d, input logic d_sat, input logic clr);
        reset   = rst;
        enable  = en;
        din     = d;
        din_sat = d_sat;
        clear   = clr;
        @(posedge clk);
        #1;
        err_seen     += int'(err);
        err_sat_seen += int'(err_sat);
        if (!locked) unlock_seen++;
    endtask

    task sendBit(input logic flip, input logic flip_sat, input logic clr);
        logic b;
        b   = gen[15];
        gen = {gen[14:0], 1'b0} ^ (gen[15] ? DEFAULT_TAPS : 16'h0000);
        applyStimulus(1'b0, 1'b1, b ^ flip, b ^ flip_sat, clr);
    endtask

    task gapCycle();
        applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task sendBits(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) gapCycle();
            sendBit(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Acquisition from any state takes exactly 16 enabled bits.
    task relock(input string tag);
        for (int i = 1; i <= 16; i++) begin
            if ($urandom_range(0, 2) == 0) gapCycle();
            sendBit(1'b0, 1'b0, 1'b0);
            if (i == 15) checkOutput({tag, "_locked_at15"}, 32'(locked), 32'd0);
            if (i == 16) checkOutput({tag, "_locked_at16"}, 32'(locked), 32'd1);
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("reset_locked", 32'(locked), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_count", 32'(err_count), 32'd0);
        checkOutput("reset_loc", 32'(dut.loc), 32'h0000FFFF);

        relock("acq");
        checkOutput("acq_sat_locked", 32'(locked_sat), 32'd1);
        err_seen = 0;
        unlock_seen = 0;
        sendBits(984);
        checkOutput("stream_err_pulses", 32'(err_seen), 32'd0);
        checkOutput("stream_unlocks", 32'(unlock_seen), 32'd0);
        checkOutput("stream_count", 32'(err_count), 32'd0);

        err_seen = 0;
        unlock_seen = 0;
        sendBits(199);
        sendBit(1'b1, 1'b0, 1'b0);
        checkOutput("flip_err_pulse", 32'(err), 32'd1);
        sendBit(1'b0, 1'b0, 1'b0);
        checkOutput("flip_err_clear", 32'(err), 32'd0);
        sendBits(20);
        checkOutput("flip_pulses", 32'(err_seen), 32'd1);
        checkOutput("flip_count", 32'(err_count), 32'd1);
        checkOutput("flip_unlocks", 32'(unlock_seen), 32'd0);
        checkOutput("flip_sat_count", 32'(err_count_sat), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clear_count", 32'(err_count), 32'd0);
        gen = {gen[14:0], 1'b0} ^ (gen[15] ? DEFAULT_TAPS : 16'h0000);
        lost = 1'b0;
        for (int i = 0; i < 2000 && !lost; i++) begin
            sendBit(1'b0, 1'b0, 1'b0);
            if (!locked) lost = 1'b1;
        end
        checkOutput("slip_lock_lost", 32'(lost), 32'd1);
        checkOutput("slip_count_ge4", 32'(err_count >= 16'd4), 32'd1);
        relock("slip");
        err_seen = 0;
        sendBits(50);
        checkOutput("slip_quiet", 32'(err_seen), 32'd0);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) sendBit(1'b0, 1'b0, 1'b0);
        checkOutput("sat_locked", 32'(locked_sat), 32'd1);
        for (int i = 0; i < 14; i++) sendBit(1'b0, 1'b1, 1'b0);
        checkOutput("sat_preload", 32'(err_count_sat), 32'hE);
        sendBit(1'b0, 1'b0, 1'b0);
        err_sat_seen = 0;
        for (int i = 0; i < 3; i++) sendBit(1'b0, 1'b1, 1'b0);
        checkOutput("sat_count", 32'(err_count_sat), 32'hF);
        checkOutput("sat_pulses", 32'(err_sat_seen), 32'd3);
        checkOutput("sat_still_locked", 32'(locked_sat), 32'd1);
        sendBit(1'b0, 1'b1, 1'b1);
        checkOutput("sat_clear_wins", 32'(err_count_sat), 32'd0);
        checkOutput("sat_clear_err", 32'(err_sat), 32'd1);

        sendBit(1'b1, 1'b0, 1'b0);
        checkOutput("prerst_count", 32'(err_count), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("midrst_locked", 32'(locked), 32'd0);
        checkOutput("midrst_count", 32'(err_count), 32'd0);
        checkOutput("midrst_err", 32'(err), 32'd0);
        relock("midrst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
